io_intr_ctrl: RTL and testbench

Sequential I/O and interrupt controller for the 5-bit-opcode core. It owns the FGI/FGO/IEN flags and the INPR/OUTR registers, and handshakes with the external input and output devices. It takes the decoder's single-cycle strobes (rFI, rFO, sFO, ION, IOF, IN, OUT, HLT) and sequences interrupt entry and halt/wake by stalling the core and steering its PC.

---
 rtl/io_intr_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_io_intr_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_intr_ctrl.sv
// io_intr_ctrl: I/O flag and interrupt sequencer for the 5-bit-opcode core.
// Owns FGI/FGO/IEN, INPR/OUTR, handshakes with the input/output devices and
// steps the core through interrupt entry (save PC, load vector) and halt/wake.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   rfi/rfo/sfo/ion/iof   decoder flag strobes (ignored while stall=1)
//   in_op/out_op/hlt      decoder instruction strobes (ignored while stall=1)
//   instr_done            core retires an instruction (interrupt check point)
//   acc                   datapath value latched into OUTR on OUT
//   in_req/in_data/in_ack input device handshake
//   out_valid/out_data/out_ack output device handshake
//   inpr, fgi, fgo, ien   architectural registers/flags
//   stall, save_pc, pc_load, pc_vector, halted   core sequencing controls
module io_intr_ctrl #(
   parameter int unsigned   DATA_W  = 8,
   parameter int unsigned   PC_W    = 8,
   parameter logic [PC_W-1:0] INT_VEC = PC_W'(1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rfi,
   input  logic              rfo,
   input  logic              sfo,
   input  logic              ion,
   input  logic              iof,
   input  logic              in_op,
   input  logic              out_op,
   input  logic              hlt,
   input  logic              instr_done,
   input  logic [DATA_W-1:0] acc,
   input  logic              in_req,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ack,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ack,
   output logic [DATA_W-1:0] inpr,
   output logic              fgi,
   output logic              fgo,
   output logic              ien,
   output logic              stall,
   output logic              save_pc,
   output logic              pc_load,
   output logic [PC_W-1:0]   pc_vector,
   output logic              halted
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_INT_SAVE = 2'd1,
      ST_INT_JUMP = 2'd2,
      ST_HALT     = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic              fgi_q, fgi_d;
   logic              fgo_q, fgo_d;
   logic              ien_q, ien_d;
   logic [DATA_W-1:0] inpr_q, inpr_d;
   logic [DATA_W-1:0] outr_q, outr_d;
   logic              in_ack_q, in_ack_d;
   logic              out_valid_q, out_valid_d;
   logic              stall_q, stall_d;
   logic              save_pc_q, save_pc_d;
   logic              pc_load_q, pc_load_d;
   logic              halted_q, halted_d;

   // Decoder strobes gated by stall; irq uses pre-update register values.
   logic rfi_g, rfo_g, sfo_g, ion_g, iof_g, out_op_g, hlt_g;
   logic irq;
   logic capture;
   logic int_enter;

   always_comb begin
      rfi_g    = rfi    & ~stall_q;
      rfo_g    = rfo    & ~stall_q;
      sfo_g    = sfo    & ~stall_q;
      ion_g    = ion    & ~stall_q;
      iof_g    = iof    & ~stall_q;
      out_op_g = out_op & ~stall_q;
      hlt_g    = hlt    & ~stall_q;
      irq      = ien_q & (fgi_q | fgo_q);
   end

   // IN only reads inpr in the datapath; the strobe has no side effect here.
   logic unused_in_op;
   assign unused_in_op = in_op;

   // Next-state and registered control outputs.
   always_comb begin
      state_d   = state_q;
      int_enter = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (instr_done && irq) begin
               state_d   = ST_INT_SAVE;
               int_enter = 1'b1;
            end else if (hlt_g) begin
               state_d = ST_HALT;
            end
         end
         ST_INT_SAVE: state_d = ST_INT_JUMP;
         ST_INT_JUMP: state_d = ST_RUN;
         ST_HALT: begin
            if (irq) begin
               state_d   = ST_INT_SAVE;
               int_enter = 1'b1;
            end
         end
         default: state_d = ST_RUN;
      endcase
      stall_d   = (state_d != ST_RUN);
      save_pc_d = (state_d == ST_INT_SAVE);
      pc_load_d = (state_d == ST_INT_JUMP);
      halted_d  = (state_d == ST_HALT);
   end

   // Flags and data registers; device handshakes run regardless of stall.
   always_comb begin
      fgi_d    = fgi_q;
      fgo_d    = fgo_q;
      ien_d    = ien_q;
      inpr_d   = inpr_q;
      outr_d   = outr_q;
      in_ack_d = 1'b0;

      // A same-cycle rfi blocks capture so the new data is not lost under the clear.
      capture = ~fgi_q & in_req & ~rfi_g;
      if (rfi_g) begin
         fgi_d = 1'b0;
      end else if (capture) begin
         fgi_d    = 1'b1;
         inpr_d   = in_data;
         in_ack_d = 1'b1;
      end

      if (out_op_g) outr_d = acc;

      // Priority: rfo over sfo and over device acceptance.
      if (rfo_g) begin
         fgo_d = 1'b0;
      end else if (sfo_g) begin
         fgo_d = 1'b1;
      end else if (~fgo_q && out_ack) begin
         fgo_d = 1'b1;
      end
      out_valid_d = ~fgo_d;

      if (ion_g) ien_d = 1'b1;
      if (iof_g) ien_d = 1'b0;
      if (int_enter) ien_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_RUN;
         fgi_q       <= 1'b0;
         fgo_q       <= 1'b1;
         ien_q       <= 1'b0;
         inpr_q      <= '0;
         outr_q      <= '0;
         in_ack_q    <= 1'b0;
         out_valid_q <= 1'b0;
         stall_q     <= 1'b0;
         save_pc_q   <= 1'b0;
         pc_load_q   <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         fgi_q       <= fgi_d;
         fgo_q       <= fgo_d;
         ien_q       <= ien_d;
         inpr_q      <= inpr_d;
         outr_q      <= outr_d;
         in_ack_q    <= in_ack_d;
         out_valid_q <= out_valid_d;
         stall_q     <= stall_d;
         save_pc_q   <= save_pc_d;
         pc_load_q   <= pc_load_d;
         halted_q    <= halted_d;
      end
   end

   assign fgi       = fgi_q;
   assign fgo       = fgo_q;
   assign ien       = ien_q;
   assign inpr      = inpr_q;
   assign out_data  = outr_q;
   assign in_ack    = in_ack_q;
   assign out_valid = out_valid_q;
   assign stall     = stall_q;
   assign save_pc   = save_pc_q;
   assign pc_load   = pc_load_q;
   assign halted    = halted_q;
   assign pc_vector = INT_VEC;

endmodule

// File: tb/tb_io_intr_ctrl.sv
// Directed self-checking bench for io_intr_ctrl.
module tb_io_intr_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       rfi, rfo, sfo, ion, iof, in_op, out_op, hlt, instr_done;
   logic [7:0] acc;
   logic       in_req;
   logic [7:0] in_data;
   logic       in_ack;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ack;
   logic [7:0] inpr;
   logic       fgi, fgo, ien, stall, save_pc, pc_load, halted;
   logic [7:0] pc_vector;

   int n_assert = 0;
   int n_fail   = 0;

   io_intr_ctrl #(.DATA_W(8), .PC_W(8), .INT_VEC(8'h01)) dut (
      .clk(clk), .reset(reset),
      .rfi(rfi), .rfo(rfo), .sfo(sfo), .ion(ion), .iof(iof),
      .in_op(in_op), .out_op(out_op), .hlt(hlt), .instr_done(instr_done),
      .acc(acc), .in_req(in_req), .in_data(in_data), .in_ack(in_ack),
      .out_valid(out_valid), .out_data(out_data), .out_ack(out_ack),
      .inpr(inpr), .fgi(fgi), .fgo(fgo), .ien(ien), .stall(stall),
      .save_pc(save_pc), .pc_load(pc_load), .pc_vector(pc_vector),
      .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic st, input logic sp,
                          input logic pl, input logic hl);
      chk({tag, ".stall"},   32'(stall),   32'(st));
      chk({tag, ".save_pc"}, 32'(save_pc), 32'(sp));
      chk({tag, ".pc_load"}, 32'(pc_load), 32'(pl));
      chk({tag, ".halted"},  32'(halted),  32'(hl));
   endtask

   task automatic chk_flags(input string tag, input logic ei, input logic eo, input logic ee);
      chk({tag, ".fgi"}, 32'(fgi), 32'(ei));
      chk({tag, ".fgo"}, 32'(fgo), 32'(eo));
      chk({tag, ".ien"}, 32'(ien), 32'(ee));
   endtask

   initial begin
      reset = 1'b1; rfi = 0; rfo = 0; sfo = 0; ion = 0; iof = 0;
      in_op = 0; out_op = 0; hlt = 0; instr_done = 0; acc = 8'h00;
      in_req = 0; in_data = 8'h00; out_ack = 0;
      tick(); tick();

      // Reset state
      chk_flags("rst", 1'b0, 1'b1, 1'b0);
      chk("rst.inpr", 32'(inpr), 32'h00);
      chk("rst.out_data", 32'(out_data), 32'h00);
      chk("rst.out_valid", 32'(out_valid), 32'h0);
      chk("rst.in_ack", 32'(in_ack), 32'h0);
      chk_ctl("rst", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst.pc_vector", 32'(pc_vector), 32'h01);
      reset = 1'b0;

      // Input capture
      in_req = 1; in_data = 8'hA5; tick();
      chk("cap1.inpr", 32'(inpr), 32'hA5);
      chk("cap1.fgi", 32'(fgi), 32'h1);
      chk("cap1.in_ack", 32'(in_ack), 32'h1);
      in_data = 8'h3C; tick();
      chk("hold.in_ack", 32'(in_ack), 32'h0);
      chk("hold.inpr", 32'(inpr), 32'hA5);
      tick();
      chk("hold2.inpr", 32'(inpr), 32'hA5);
      rfi = 1; tick();
      chk("rfi.fgi", 32'(fgi), 32'h0);
      chk("rfi.inpr", 32'(inpr), 32'hA5);
      rfi = 0; tick();
      chk("cap2.inpr", 32'(inpr), 32'h3C);
      chk("cap2.fgi", 32'(fgi), 32'h1);
      chk("cap2.in_ack", 32'(in_ack), 32'h1);
      // rfi coinciding with a capture condition: clear wins, no capture
      in_data = 8'h77; rfi = 1; tick();
      chk("rfi2.fgi", 32'(fgi), 32'h0);
      tick();
      chk("rfi_cap.fgi", 32'(fgi), 32'h0);
      chk("rfi_cap.inpr", 32'(inpr), 32'h3C);
      chk("rfi_cap.in_ack", 32'(in_ack), 32'h0);
      rfi = 0; tick();
      chk("cap3.inpr", 32'(inpr), 32'h77);
      chk("cap3.in_ack", 32'(in_ack), 32'h1);
      in_req = 0; tick();
      chk("cap3b.in_ack", 32'(in_ack), 32'h0);

      // Output path
      acc = 8'h5A; out_op = 1; tick();
      chk("out.out_data", 32'(out_data), 32'h5A);
      chk("out.fgo", 32'(fgo), 32'h1);
      chk("out.out_valid", 32'(out_valid), 32'h0);
      out_op = 0; rfo = 1; tick();
      chk("rfo.fgo", 32'(fgo), 32'h0);
      chk("rfo.out_valid", 32'(out_valid), 32'h1);
      rfo = 0; out_ack = 1; tick();
      chk("ack.fgo", 32'(fgo), 32'h1);
      chk("ack.out_valid", 32'(out_valid), 32'h0);
      rfo = 1; tick();
      chk("rfo_ack.fgo", 32'(fgo), 32'h0);
      chk("rfo_ack.out_valid", 32'(out_valid), 32'h1);
      out_ack = 0; rfo = 0; sfo = 1; tick();
      chk("sfo.fgo", 32'(fgo), 32'h1);
      rfo = 1; tick();
      chk("rfo_sfo.fgo", 32'(fgo), 32'h0);
      rfo = 0; tick();
      chk("sfo2.fgo", 32'(fgo), 32'h1);
      sfo = 0;

      // No entry while ien=0; ion+iof together leaves ien clear
      instr_done = 1; tick();
      chk_ctl("noent", 1'b0, 1'b0, 1'b0, 1'b0);
      instr_done = 0; ion = 1; iof = 1; tick();
      chk("ioniof.ien", 32'(ien), 32'h0);
      ion = 0; iof = 0; rfo = 1; tick();
      rfo = 0; rfi = 1; tick();
      rfi = 0;
      chk_flags("pre_int", 1'b0, 1'b0, 1'b0);
      ion = 1; tick();
      ion = 0;
      chk("ion.ien", 32'(ien), 32'h1);
      instr_done = 1; tick();
      chk_ctl("noirq", 1'b0, 1'b0, 1'b0, 1'b0);
      instr_done = 0; in_req = 1; in_data = 8'hC3; tick();
      in_req = 0;
      chk("int.fgi", 32'(fgi), 32'h1);
      chk("int.inpr", 32'(inpr), 32'hC3);

      // Interrupt entry
      instr_done = 1; tick();
      instr_done = 0;
      chk_ctl("save", 1'b1, 1'b1, 1'b0, 1'b0);
      chk("save.ien", 32'(ien), 32'h0);
      sfo = 1; tick();
      sfo = 0;
      chk_ctl("jump", 1'b1, 1'b0, 1'b1, 1'b0);
      chk("jump.pc_vector", 32'(pc_vector), 32'h01);
      chk("jump.sfo_ignored", 32'(fgo), 32'h0);
      tick();
      chk_ctl("ret", 1'b0, 1'b0, 1'b0, 1'b0);
      instr_done = 1; tick();
      instr_done = 0;
      chk_ctl("once", 1'b0, 1'b0, 1'b0, 1'b0);

      // Halt with ien=0 stays halted; strobes ignored
      hlt = 1; tick();
      hlt = 0;
      chk_ctl("halt", 1'b1, 1'b0, 1'b0, 1'b1);
      tick(); tick(); tick();
      chk_ctl("halt3", 1'b1, 1'b0, 1'b0, 1'b1);
      ion = 1; tick();
      ion = 0;
      chk("halt.ion_ignored", 32'(ien), 32'h0);
      chk("halt.still", 32'(halted), 32'h1);
      reset = 1; tick();
      reset = 0;
      chk_ctl("halt_rst", 1'b0, 1'b0, 1'b0, 1'b0);
      chk_flags("halt_rst", 1'b0, 1'b1, 1'b0);

      // Halt with ien=1, woken by device input
      rfo = 1; tick();
      rfo = 0; ion = 1; tick();
      ion = 0; hlt = 1; tick();
      hlt = 0;
      chk_ctl("halt2", 1'b1, 1'b0, 1'b0, 1'b1);
      chk("halt2.ien", 32'(ien), 32'h1);
      tick();
      chk("halt2.stay", 32'(halted), 32'h1);
      in_req = 1; in_data = 8'hE7; tick();
      in_req = 0;
      chk("wake.fgi", 32'(fgi), 32'h1);
      chk("wake.in_ack", 32'(in_ack), 32'h1);
      chk("wake.inpr", 32'(inpr), 32'hE7);
      chk("wake.halted", 32'(halted), 32'h1);
      tick();
      chk_ctl("wake_save", 1'b1, 1'b1, 1'b0, 1'b0);
      chk("wake_save.ien", 32'(ien), 32'h0);
      tick();
      chk_ctl("wake_jump", 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      chk_ctl("wake_run", 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset during INT_SAVE
      ion = 1; tick();
      ion = 0; instr_done = 1; tick();
      instr_done = 0;
      chk_ctl("rsave", 1'b1, 1'b1, 1'b0, 1'b0);
      reset = 1; tick();
      reset = 0;
      chk_ctl("rsave_rst", 1'b0, 1'b0, 1'b0, 1'b0);
      chk_flags("rsave_rst", 1'b0, 1'b1, 1'b0);
      tick();
      chk_ctl("rsave_after", 1'b0, 1'b0, 1'b0, 1'b0);

      // Interrupt beats a coincident hlt
      ion = 1; tick();
      ion = 0; hlt = 1; instr_done = 1; tick();
      hlt = 0; instr_done = 0;
      chk_ctl("irq_hlt", 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      chk_ctl("irq_hlt_jump", 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      chk_ctl("irq_hlt_run", 1'b0, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
